// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic grid edge logic.
// Holds the feeder state encoding, a constant-safe clog2 and the common width defaults.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feeder_state_t;

    localparam int default_data_width   = 16;
    localparam int default_result_width = 2 * default_data_width + 8;

    // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/input_skew_feeder_skew_lane.sv
// One skew lane: a DEPTH-stage {data, valid} delay chain with synchronous reset and enable.
// Lane i of the feeder uses DEPTH = i+1, so its element trails lane 0 by i cycles.
module skew_lane #(
    parameter int data_width = 16,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [data_width-1:0] data_in,
    input  logic                  valid_in,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out
);

    logic [DEPTH-1:0][data_width-1:0] data_q;
    logic [DEPTH-1:0]                 valid_q;

    // NOTE: the data stages are reset too, so the grid edge reads zero rather than stale operands after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
        end else if (enable) begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value, forming a true shift.
            data_q[0]  <= data_in;
            valid_q[0] <= valid_in;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign data_out  = data_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];

endmodule

// File: rtl/input_skew_feeder.sv
// Skews unskewed N-lane operand vectors onto a systolic grid edge and appends N-1 flush cycles per tile.
// Also tracks tile bookkeeping: busy, done pulse, beat count and sticky overflow.
module input_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N          = 4,
    parameter int data_width = default_data_width,
    parameter int K_MAX      = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [0:N-1][data_width-1:0]    in_data,
    output logic [0:N-1][data_width-1:0]    lane_output,
    output logic [N-1:0]                    lane_valid,
    output logic                            busy,
    output logic                            done,
    output logic [clog2(K_MAX+1)-1:0]       beat_count,
    output logic                            overflow
);

    localparam int BEAT_W     = clog2(K_MAX + 1);
    localparam int FLUSH_W    = (N > 1) ? clog2(N) : 1;
    localparam int FLUSH_LAST = (N > 1) ? N - 2 : 0;
    localparam bit SINGLE     = (N == 1);

    feeder_state_t        state, state_next;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [BEAT_W-1:0]    beat_base;
    logic                 accept;
    logic                 flush_end;
    logic                 tile_end;

    assign accept    = in_valid && in_ready;
    assign flush_end = (state == FLUSH) && (flush_cnt == FLUSH_W'(FLUSH_LAST));
    // With a single lane the last element is already on lane N-1 after the accepting edge.
    assign tile_end  = flush_end || (SINGLE && accept && in_last);
    assign beat_base = done ? '0 : beat_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // NOTE: state_next takes a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = in_last ? (SINGLE ? IDLE : FLUSH) : STREAM;
            STREAM:  if (accept && in_last) state_next = SINGLE ? IDLE : FLUSH;
            FLUSH:   if (flush_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = enable && !reset && (state != FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt  <= '0;
            done       <= 1'b0;
            beat_count <= '0;
            overflow   <= 1'b0;
        end else if (enable) begin
            if (state == FLUSH && !flush_end) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
            done <= tile_end;
            // The count restarts in the cycle after done, even if that cycle also accepts.
            if (accept && beat_base == BEAT_W'(K_MAX)) begin
                overflow   <= 1'b1;
                beat_count <= beat_base;
            end else if (accept) begin
                beat_count <= beat_base + 1'b1;
            end else begin
                beat_count <= beat_base;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(
            .data_width(data_width),
            .DEPTH     (i + 1)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .data_in  (accept ? in_data[i] : '0),
            .valid_in (accept),
            .data_out (lane_output[i]),
            .valid_out(lane_valid[i])
        );
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder: directed tiles push expected lane elements and done times,
// a negedge monitor pops them whenever the DUT presents valid lanes or done.
module tb_input_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset, enable, in_valid, in_last;
    logic [0:N-1][DW-1:0] in_data;

    logic                 in_ready, busy, done, overflow;
    logic [0:N-1][DW-1:0] lane_output;
    logic [N-1:0]         lane_valid;
    logic [8:0]           beat_count;

    logic                 k_in_ready, k_busy, k_done, k_overflow;
    logic [0:N-1][DW-1:0] k_lane_output;
    logic [N-1:0]         k_lane_valid;
    logic [1:0]           k_beat_count;

    logic                 in_valid1, in_last1;
    logic [0:0][DW-1:0]   in_data1;
    logic                 o_in_ready, o_busy, o_done, o_overflow;
    logic [0:0][DW-1:0]   o_lane_output;
    logic [0:0]           o_lane_valid;
    logic [8:0]           o_beat_count;

    input_skew_feeder #(.N(N), .data_width(DW), .K_MAX(256)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .lane_output(lane_output), .lane_valid(lane_valid),
        .busy(busy), .done(done), .beat_count(beat_count), .overflow(overflow));

    input_skew_feeder #(.N(N), .data_width(DW), .K_MAX(2)) dut_k (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(k_in_ready),
        .in_last(in_last), .in_data(in_data), .lane_output(k_lane_output), .lane_valid(k_lane_valid),
        .busy(k_busy), .done(k_done), .beat_count(k_beat_count), .overflow(k_overflow));

    input_skew_feeder #(.N(1), .data_width(DW), .K_MAX(256)) dut_one (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid1), .in_ready(o_in_ready),
        .in_last(in_last1), .in_data(in_data1), .lane_output(o_lane_output), .lane_valid(o_lane_valid),
        .busy(o_busy), .done(o_done), .beat_count(o_beat_count), .overflow(o_overflow));

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            when;
    } item_t;

    item_t lane_q [N][$];
    int    done_q [$];

    // Enabled, non-reset edges seen so far; every expected time is expressed in this count.
    int ecnt         = 0;
    bit last_edge_en = 1'b0;

    always @(posedge clk) begin
        last_edge_en <= enable && !reset;
        if (enable && !reset) ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (!reset && last_edge_en) begin
            for (int i = 0; i < N; i++) begin
                if (lane_valid[i]) begin
                    if (lane_q[i].size() == 0) begin
                        check($sformatf("lane%0d_unexpected_valid", i), lane_valid[i], 0);
                    end else begin
                        item_t it;
                        it = lane_q[i].pop_front();
                        check($sformatf("lane%0d_data", i), lane_output[i], it.data);
                        check($sformatf("lane%0d_time", i), ecnt, it.when);
                    end
                end else begin
                    check($sformatf("lane%0d_bubble_zero", i), lane_output[i], 0);
                    if (lane_q[i].size() > 0 && lane_q[i][0].when <= ecnt)
                        check($sformatf("lane%0d_missing", i), lane_valid[i], 1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    int w;
                    w = done_q.pop_front();
                    check("done_time", ecnt, w);
                end
            end else if (done_q.size() > 0 && done_q[0] <= ecnt) begin
                check("done_missing", done, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d, input logic last);
        item_t it;
        in_valid   = 1'b1;
        in_last    = last;
        in_data[0] = a;
        in_data[1] = b;
        in_data[2] = c;
        in_data[3] = d;
        #1;
        check("in_ready_before_accept", in_ready, 1);
        step();
        for (int i = 0; i < N; i++) begin
            it.data = in_data[i];
            it.when = ecnt + i;
            lane_q[i].push_back(it);
        end
        if (last) done_q.push_back(ecnt + N - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    logic [0:N-1][DW-1:0] snap_data;
    logic [N-1:0]         snap_valid;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        in_data1  = '0;
        idle(2);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_beat_count", beat_count, 0);
        check("reset_lane_valid", lane_valid, 0);
        check("reset_lane_output", lane_output, 0);
        check("reset_overflow", overflow, 0);
        reset = 1'b0;
        step();

        // Single tile of three vectors; dut_k (K_MAX=2) overflows on the third accept.
        send(1, 2, 3, 4, 1'b0);
        send(5, 6, 7, 8, 1'b0);
        check("kmax_no_overflow_yet", k_overflow, 0);
        send(9, 10, 11, 12, 1'b1);
        check("beat_count_3", beat_count, 3);
        check("busy_in_flush", busy, 1);
        check("kmax_overflow_set", k_overflow, 1);
        check("kmax_beat_saturated", k_beat_count, 2);
        for (int k = 1; k < N; k++) begin
            check($sformatf("in_ready_flush_%0d", k), in_ready, 0);
            step();
        end
        check("done_cycle_done", done, 1);
        check("done_cycle_in_ready", in_ready, 1);
        check("done_cycle_busy", busy, 0);
        check("done_cycle_beat_count", beat_count, 3);
        step();
        check("after_done_beat_clear", beat_count, 0);
        check("after_done_done_low", done, 0);
        check("kmax_overflow_sticky", k_overflow, 1);

        // Two-cycle bubble between the first and second vector.
        send(21, 22, 23, 24, 1'b0);
        idle(2);
        send(25, 26, 27, 28, 1'b0);
        send(29, 30, 31, 32, 1'b1);
        idle(N + 1);

        // Enable low for three cycles mid-flush, then hold the pending done for two cycles.
        send(41, 42, 43, 44, 1'b0);
        send(45, 46, 47, 48, 1'b1);
        step();
        snap_data  = lane_output;
        snap_valid = lane_valid;
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("frozen_lane_output", lane_output, snap_data);
            check("frozen_lane_valid", lane_valid, snap_valid);
            check("frozen_in_ready", in_ready, 0);
            check("frozen_busy", busy, 1);
        end
        enable = 1'b1;
        step();
        check("stretched_not_done_yet", done, 0);
        step();
        check("stretched_done", done, 1);
        enable = 1'b0;
        step();
        check("done_held_while_disabled", done, 1);
        step();
        enable = 1'b1;
        step();
        check("done_cleared_after_enabled_cycle", done, 0);
        idle(N);
        check("kmax_overflow_still_set", k_overflow, 1);

        // Reset in the middle of STREAM discards everything in flight.
        send(51, 52, 53, 54, 1'b0);
        send(55, 56, 57, 58, 1'b0);
        reset = 1'b1;
        step();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        check("midreset_lane_valid", lane_valid, 0);
        check("midreset_lane_output", lane_output, 0);
        check("midreset_busy", busy, 0);
        check("midreset_beat_count", beat_count, 0);
        check("midreset_kmax_overflow", k_overflow, 0);
        reset = 1'b0;
        step();

        // Tile after reset, then a back-to-back one-vector tile accepted in the done cycle.
        send(1, 2, 3, 4, 1'b0);
        send(5, 6, 7, 8, 1'b0);
        send(9, 10, 11, 12, 1'b1);
        idle(N - 1);
        check("b2b_done_cycle", done, 1);
        send(61, 62, 63, 64, 1'b1);
        check("b2b_beat_count_restart", beat_count, 1);
        check("b2b_busy", busy, 1);
        idle(N + 1);
        check("b2b_idle", busy, 0);

        // Single-lane instance: one in_last vector, done one cycle later with no flush.
        in_valid1   = 1'b1;
        in_last1    = 1'b1;
        in_data1[0] = 16'd77;
        #1;
        check("n1_in_ready", o_in_ready, 1);
        step();
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        in_data1  = '0;
        check("n1_done", o_done, 1);
        check("n1_lane_valid", o_lane_valid, 1);
        check("n1_lane_output", o_lane_output, 77);
        check("n1_busy", o_busy, 0);
        check("n1_in_ready_after", o_in_ready, 1);
        check("n1_beat_count", o_beat_count, 1);
        step();
        check("n1_done_pulse_end", o_done, 0);
        check("n1_beat_clear", o_beat_count, 0);

        for (int i = 0; i < N; i++)
            check($sformatf("lane%0d_queue_drained", i), lane_q[i].size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
